// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter slice.
// Flag bit positions, FSM state type and default widths.
package alu_pkg;

  localparam int ALU_W     = 4;
  localparam int ALU_SEL_W = 4;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request/response handshake bundle between two requesters
// and the ALU arbiter; requester i owns bit i / slice i.
interface alu_req_arbiter_if
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int SEL_W = ALU_SEL_W
);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*W-1:0]     req_a;
  logic [2*W-1:0]     req_b;
  logic [2*SEL_W-1:0] req_sel;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [W-1:0]       rsp_result;
  logic [3:0]         rsp_flags;

  modport master (
    output req_valid, req_a, req_b,
    output req_sel, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  req_sel, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_result, rsp_flags
  );

endinterface

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester
// that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // Pick one requester, alternating on ties.
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    unique case (1'b1)
      (req == 2'b11): begin
        gnt_idx = ~last;
        gnt     = last ? 2'b01 : 2'b10;
      end
      (req == 2'b01): begin
        gnt_idx = 1'b0;
        gnt     = 2'b01;
      end
      (req == 2'b10): begin
        gnt_idx = 1'b1;
        gnt     = 2'b10;
      end
      default: begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters:
// accept, execute for one cycle, hold the response.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int SEL_W = ALU_SEL_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_req_arbiter_if.slave bus,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [W-1:0]     alu_out,
  input  logic [3:0]       alu_flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_e             state_q;
  logic               last_q;
  logic               owner_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [SEL_W-1:0]   sel_q;
  logic [W-1:0]       res_q;
  logic [3:0]         flg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         rsp_valid_q;
  logic               busy_q;

  logic [1:0]         gnt;
  logic               gnt_idx;
  logic               accept;

  rr_arb2 u_arb (
    .req     (bus.req_valid),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Requests are only offered a grant while idle.
  always_comb begin
    bus.req_ready = 2'b00;
    if (state_q == ST_IDLE)
      bus.req_ready = gnt;
  end

  assign accept = |(bus.req_valid & bus.req_ready);

  // Single FSM: operand capture, result capture, response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      res_q       <= '0;
      flg_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= gnt_idx ? bus.req_a[2*W-1:W]
                               : bus.req_a[W-1:0];
            b_q     <= gnt_idx ? bus.req_b[2*W-1:W]
                               : bus.req_b[W-1:0];
            sel_q   <= gnt_idx
                     ? bus.req_sel[2*SEL_W-1:SEL_W]
                     : bus.req_sel[SEL_W-1:0];
            owner_q <= gnt_idx;
            last_q  <= gnt_idx;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q       <= alu_out;
          flg_q       <= alu_flags;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready[owner_q]) begin
            cnt_q       <= cnt_q + CNT_W'(1);
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_sel        = sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flg_q;
  assign busy           = busy_q;
  assign op_count       = cnt_q;

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one combinational 4-bit ALU (A, B, ALU_Sel in; ALU_Out, Carry/Zero/Negative/Overflow out) between two requesters.
- Round-robin arbitration with valid/ready handshakes on both request and response sides.
- Registers the operands, captures the ALU result and flags one cycle later, and returns them to the requester that was granted.
- Sits in front of the ALU inside the top-level wrapper.

Parameters:
- W, 4, ALU operand/result width.
- SEL_W, 4, ALU opcode width (passed through; never decoded here).
- CNT_W, 8, width of completed-operation counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester request accept
- req_a  in  2*W  operand A; requester i at [i*W +: W]
- req_b  in  2*W  operand B; same packing
- req_sel  in  2*SEL_W  opcode; requester i at [i*SEL_W +: SEL_W]
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_result  out  W  captured ALU result (shared by both requesters; qualified by rsp_valid)
- rsp_flags  out  4  captured flags {Carry, Zero, Negative, Overflow}, bit3..bit0
- alu_a  out  W  operand to ALU
- alu_b  out  W  operand to ALU
- alu_sel  out  SEL_W  opcode to ALU
- alu_out  in  W  ALU result (combinational from alu_a/alu_b/alu_sel)
- alu_flags  in  4  ALU flags, same bit order as rsp_flags
- busy  out  1  high whenever state is not IDLE
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie), owner=0;
  - alu_a/alu_b/alu_sel=0, rsp_result=0, rsp_flags=0, op_count=0;
  - rsp_valid=0, busy=0.
- FSM has three states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant g is combinational. Both valid -> g = ~last_grant. One valid -> that one. None -> no grant.
  - req_ready[g]=1 only for the granted requester. req_ready=0 in every other state.
  - On req_valid[g] & req_ready[g]: register req_a/req_b/req_sel slice g onto alu_a/alu_b/alu_sel, set owner<=g and last_grant<=g, go to EXEC.
- EXEC (exactly 1 cycle):
  - Capture rsp_result<=alu_out and rsp_flags<=alu_flags from the registered operands.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1; the other bit stays 0.
  - rsp_result/rsp_flags are held stable.
  - On rsp_ready[owner]: op_count<=op_count+1 (wrapping), go to IDLE.
  - rsp_ready on the non-owner bit is ignored.
- Latency and throughput:
  - Request handshake to rsp_valid is 2 cycles.
  - Back-to-back ops take at least 3 cycles each (IDLE accept, EXEC, RESP with immediate ready).
  - No request is accepted in the cycle a response completes.
- Operands on alu_* hold their last value outside EXEC; they change only on request acceptance.
- Protocol:
  - A requester keeps valid and its payload stable until ready.
  - Dropping valid before ready is not checked and causes no state change.
- A stalled response (rsp_ready held low) blocks both requesters indefinitely. This is intended back-pressure.
- Starvation-free: under continuous dual requests, grants strictly alternate 0,1,0,1...
- Reset asserted in EXEC or RESP abandons the op. No response is issued, and op_count is not incremented.
- alu_sel is opaque to this block. Undefined opcodes are passed through and whatever the ALU returns is captured.

Decomposition:
- Shared package alu_pkg holds:
  - FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0 (flag bit indices);
  - a state enum {ST_IDLE, ST_EXEC, ST_RESP};
  - W and SEL_W defaults.
- One sub-module, rr_arb2: the combinational two-way round-robin grant (inputs req[1:0], last; outputs gnt[1:0], gnt_idx).
- The FSM, operand/result registers and counter stay in alu_req_arbiter.

Test Plan:
- The bench instantiates the real 4-bit ALU on the alu_* ports, plus a reference model keyed on the same opcodes.
- Single request:
  - Stimulus: reset, then requester 0 with a=4'h3, b=4'h5, opcode ADD, rsp_ready[0]=1.
  - Required: req_ready[0] high the same cycle; rsp_valid[0] exactly 2 cycles after the handshake; rsp_result=4'h8, flags match the model; op_count=1; busy low afterwards.
- Tie on first arbitration:
  - Stimulus: both requesters valid immediately after reset.
  - Required: requester 0 granted first, requester 1 next; rsp_valid never has both bits high.
- Continuous dual requests for 10 ops:
  - Required: grant order 0,1,0,1,...; each requester gets 5 responses; op_count=10; every op spans at least 3 cycles.
- Response back-pressure:
  - Stimulus: hold rsp_ready[1]=0 for 6 cycles during requester 1's RESP while requester 0 is valid.
  - Required: rsp_result/rsp_flags stable, req_ready=0 throughout; requester 0 is granted only after the rsp_ready[1] handshake.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during EXEC.
  - Required: all outputs return to reset values asynchronously; no rsp_valid; op_count=0; after release the next tie goes to requester 0.
- Counter wrap:
  - Stimulus: 256 completed ops.
  - Required: op_count returns to 0; result checks against the model pass for random a, b and opcode.
